// File: rtl/pipe_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic: constants, the fetch-queue entry type and an alignment helper.
// Users import this package with pipe_pkg::*.
package pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: synchronous FIFO of fetch entries with single-cycle flush.
// Latency: a push is visible on head the cycle after; no write-through bypass.
// Backpressure: none internally; the caller's credit rule keeps it from overflowing.
module fetch_fifo
    import pipe_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      push,
    input  fetch_entry_t              push_dat,
    input  logic                      pop,
    input  logic                      flush,
    output logic [$clog2(QDEPTH):0]   count,
    output fetch_entry_t              head,
    output logic                      empty
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    r_mem [QDEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic            w_full;
    logic            w_do_push;
    logic            w_do_pop;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == CW'(QDEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~w_full | w_do_pop);
    assign count     = r_count;
    assign head      = r_mem[r_rd];

    // Storage write; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr] <= push_dat;
        end
    end

    // Pointers and occupancy; flush empties the queue ahead of push/pop.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch: next-PC select, in-order imem requests, response queue to IF/ID.
// Latency: grant at T with response at T+L gives the word on ins from T+L+1.
// Backpressure: wpcir low holds the queue head; requests stop once outstanding+queued reaches QDEPTH.
module pipe_fetch_unit
    import pipe_pkg::*;
#(
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ivalid,
    output logic [31:0] ins,
    output logic [31:0] pc4
);
    localparam int          CW         = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIM = (CW + 1)'(QDEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic          r_run;

    logic          w_redirect;
    logic [31:0]   w_target_raw;
    logic [31:0]   w_target;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW-1:0] w_outst_nxt;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_dat;

    assign w_redirect = wpcir & (pcsource != PCSRC_SEQ);

    // Redirect target select; the sequential case never loads a target.
    always_comb begin
        w_target_raw = r_fetch_pc;
        case (pcsource)
            PCSRC_BR: w_target_raw = bpc;
            PCSRC_JR: w_target_raw = ra;
            PCSRC_J:  w_target_raw = jpc;
            default:  w_target_raw = r_fetch_pc;
        endcase
    end
    assign w_target = word_align(w_target_raw);

    // Every granted-not-returned request reserves a queue slot.
    assign w_credit  = {1'b0, r_outst} + {1'b0, w_count};
    assign imem_req  = r_run & (w_credit < CREDIT_LIM);
    assign imem_addr = r_fetch_pc;
    assign w_fire    = imem_req & imem_gnt;

    assign w_outst_nxt = r_outst + CW'(w_fire) - CW'(imem_rvalid);

    // Wrong-path words (still owed from before a redirect, or arriving during one) are discarded.
    assign w_push     = imem_rvalid & (r_drop == '0) & ~w_redirect;
    assign w_pop      = wpcir & ~w_empty & ~w_redirect;
    assign w_push_dat = '{pc4: r_resp_pc + 32'd4, ins: imem_rdata};

    fetch_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .push     (w_push),
        .push_dat (w_push_dat),
        .pop      (w_pop),
        .flush    (w_redirect),
        .count    (w_count),
        .head     (w_head),
        .empty    (w_empty)
    );

    // Fetch/response PCs and in-flight bookkeeping; a redirect marks everything in flight stale.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
            r_run      <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_outst <= w_outst_nxt;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_drop     <= w_outst_nxt;
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_resp_pc  <= r_resp_pc + 32'd4;
                if (imem_rvalid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
        end
    end

    // IF/ID presentation: a nop with pc4 of zero whenever the queue is empty.
    always_comb begin
        ivalid = ~w_empty;
        ins    = NOP_INSN;
        pc4    = 32'h0;
        if (!w_empty) begin
            ins = w_head.ins;
            pc4 = w_head.pc4;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
module tb_pipe_fetch_unit;
    import pipe_pkg::*;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, ra, jpc;
    logic        wpcir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        ivalid;
    logic [31:0] ins;
    logic [31:0] pc4;

    pipe_fetch_unit #(.QDEPTH(QD), .RESET_PC(RPC)) u_dut (
        .clk(clk), .clrn(clrn), .pcsource(pcsource), .bpc(bpc), .ra(ra), .jpc(jpc),
        .wpcir(wpcir), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ivalid(ivalid), .ins(ins), .pc4(pc4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           last_due = 0;
    int           lmin = 1;
    int           lmax = 1;
    int           gnt_pct = 100;
    int           max_inflight = 0;
    int           consumed = 0;
    mreq_t        mq[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  exp_addr = RPC;
    logic         restart_pend = 1'b0;
    logic [31:0]  restart_pc = RPC;

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge (grants, consumption, scoreboard), then drive memory after posedge.
    task automatic step();
        logic         redir;
        int           due;
        mreq_t        m;
        fetch_entry_t e;
        @(negedge clk);
        if (clrn) begin
            redir = wpcir && (pcsource != 2'b00);
            if (imem_req && imem_gnt) begin
                check("grant_addr", imem_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
                due = cyc + $urandom_range(lmax, lmin);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                m.addr = imem_addr;
                m.due  = due;
                mq.push_back(m);
                if (mq.size() > max_inflight) max_inflight = mq.size();
            end
            if (wpcir && ivalid && !redir) begin
                consumed++;
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pc4", pc4, e.pc4);
                    check("ins", ins, e.ins);
                end
            end
            if (restart_pend) begin
                exp_q.delete();
                for (int i = 0; i < 1000; i++) begin
                    e.pc4 = restart_pc + 32'(4 * (i + 1));
                    e.ins = memw(restart_pc + 32'(4 * i));
                    exp_q.push_back(e);
                end
                exp_addr = restart_pc;
                restart_pend = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (clrn && mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memw(mq[0].addr);
            void'(mq.pop_front());
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
    endtask

    task automatic drive_redirect(input logic [1:0] src, input logic [31:0] tgt);
        bpc = $urandom();
        ra  = $urandom();
        jpc = $urandom();
        case (src)
            2'b01:   bpc = tgt;
            2'b10:   ra  = tgt;
            default: jpc = tgt;
        endcase
        pcsource     = src;
        wpcir        = 1'b1;
        restart_pc   = {tgt[31:2], 2'b00};
        restart_pend = 1'b1;
    endtask

    initial begin
        int n;
        int c0;
        clrn = 1'b0; wpcir = 1'b0; pcsource = 2'b00;
        bpc = 32'h0; ra = 32'h0; jpc = 32'h0;

        // Reset state
        repeat (3) step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_ivalid", 32'(ivalid), 32'd0);
        check("rst_ins", ins, 32'h0);
        check("rst_pc4", pc4, 32'h0);
        restart_pc = RPC; restart_pend = 1'b1;
        clrn = 1'b1; wpcir = 1'b1;
        #1 check("run_gate", 32'(imem_req), 32'd0);

        // Sequential stream, L=1, always granted: one instruction per cycle once primed
        for (int i = 0; i < 20; i++) begin
            step();
            if (i >= 4) check("stream_ivalid", 32'(ivalid), 32'd1);
        end

        // Decode stall for 5 cycles: queue fills, requests stop, head holds
        wpcir = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k >= 3) check("stall_req", 32'(imem_req), 32'd0);
            check("stall_pc4", pc4, exp_q[0].pc4);
            check("stall_ins", ins, exp_q[0].ins);
        end
        wpcir = 1'b1;
        repeat (15) step();

        // Taken branch with two requests in flight
        lmin = 3; lmax = 3;
        for (n = 0; n < 50 && mq.size() < 2; n++) step();
        check("br_inflight", 32'(mq.size() >= 2), 32'd1);
        drive_redirect(2'b01, 32'h100);
        step();
        pcsource = 2'b00;
        check("br_addr", imem_addr, 32'h100);
        for (n = 0; n < 40 && !ivalid; n++) step();
        check("br_ivalid", 32'(ivalid), 32'd1);
        check("br_pc4", pc4, 32'h104);
        check("br_ins", ins, memw(32'h100));

        // jr on the same cycle as a grant and a returning word
        lmin = 1; lmax = 1;
        for (n = 0; n < 30 && !(imem_rvalid && imem_req && imem_gnt); n++) step();
        check("jr_align", 32'(imem_rvalid && imem_req && imem_gnt), 32'd1);
        drive_redirect(2'b10, 32'h40);
        step();
        pcsource = 2'b00;
        check("jr_addr", imem_addr, 32'h40);
        for (n = 0; n < 40 && !ivalid; n++) step();
        check("jr_ivalid", 32'(ivalid), 32'd1);
        check("jr_pc4", pc4, 32'h44);

        // Random grant stalls, latency 1-4, decode stalls and redirects with unaligned targets
        lmin = 1; lmax = 4; gnt_pct = 70;
        c0 = consumed;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(9) < 8) begin
                if ($urandom_range(99) < 5)
                    drive_redirect(2'($urandom_range(3, 1)), $urandom() & 32'h0000_3FFF);
                else begin
                    wpcir = 1'b1; pcsource = 2'b00;
                end
            end else begin
                wpcir = 1'b0; pcsource = 2'($urandom_range(3));
            end
            step();
        end
        wpcir = 1'b1; pcsource = 2'b00; gnt_pct = 100;
        check("inflight_bound", 32'(max_inflight <= QD), 32'd1);
        check("rand_progress", 32'((consumed - c0) > 50), 32'd1);

        // Reset asserted mid-transaction
        lmin = 2; lmax = 2;
        for (n = 0; n < 30 && mq.size() < 2; n++) step();
        check("rst2_inflight", 32'(mq.size() >= 2), 32'd1);
        clrn = 1'b0;
        mq.delete(); last_due = 0; imem_rvalid = 1'b0;
        #1;
        check("rst2_req", 32'(imem_req), 32'd0);
        check("rst2_ivalid", 32'(ivalid), 32'd0);
        check("rst2_ins", ins, 32'h0);
        check("rst2_pc4", pc4, 32'h0);
        repeat (2) step();
        restart_pc = RPC; restart_pend = 1'b1;
        clrn = 1'b1;
        #1 check("rst2_run_gate", 32'(imem_req), 32'd0);
        for (n = 0; n < 10 && !imem_req; n++) step();
        check("rst2_first_req", 32'(imem_req), 32'd1);
        check("rst2_first_addr", imem_addr, RPC);
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
